period_meter: RTL and testbench
===============================

# period_meter

Measures the period, and optionally the high time, of a slow digital signal in units of `in_clk` cycles. It is the receive-side complement of the clock divider: it recovers the divisor `div` from a divided clock or any other periodic input. It sits between an external or derived periodic signal and status/readback logic, and publishes one result per input period with a single-cycle `valid` strobe.

## Interface
Parameters:
- `WIDTH`, default 32: width of the cycle counters and result outputs.
- `SYNC_STAGES`, default 2: number of flip-flops in the `sig_in` synchronizer; legal values are 2 or more.
- `TIMEOUT`, default 1_000_000: number of cycles without a rising edge before the block abandons a measurement. Legal range is 2 to 2^WIDTH-1.

Ports:
- `in_clk`, input, 1 bit: the only clock. All logic is rising-edge triggered.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `enable`, input, 1 bit: measurement enable.
- `sig_in`, input, 1 bit: signal to measure. It may be asynchronous to `in_clk`.
- `period`, output, WIDTH bits: last measured period in cycles.
- `high_time`, output, WIDTH bits: high cycles within the last measured period.
- `valid`, output, 1 bit: one-cycle strobe; `period` and `high_time` were updated this cycle.
- `timeout`, output, 1 bit: sticky flag; no rising edge arrived within `TIMEOUT` cycles.

## Operation
- **Synchronizer and edge detect**
  - `sig_in` passes through `SYNC_STAGES` flops to give `s_sync`. One further flop gives `s_prev`.
  - `rise = s_sync & ~s_prev`.
  - The synchronizer and edge flops run whenever reset is low, regardless of `enable`.
- **FSM states:** IDLE and MEASURE.
- **IDLE**
  - `cnt` and `hi_cnt` are held at 0.
  - On `enable & rise`: go to MEASURE, load `cnt<=0` and `hi_cnt<=1`. No `valid` is issued for this first edge.
- **MEASURE, when `rise` is present:**
  - `period<=cnt+1` and `high_time<=hi_cnt`.
  - `valid<=1` and `timeout<=0`.
  - Load `cnt<=0` and `hi_cnt<=1`.
- **MEASURE, when `rise` is absent:**
  - `cnt<=cnt+1`.
  - `hi_cnt<=hi_cnt+1` if `s_sync`, otherwise it holds.
- **Timeout**
  - In MEASURE, if there is no `rise` and `cnt==TIMEOUT-1`: `timeout<=1`, go to IDLE, and `period` and `high_time` hold.
  - A `rise` arriving in the same cycle wins; the result is a normal measurement.
- **`enable` low** (any state)
  - Next state is IDLE, counters clear, `valid<=0`, `timeout<=0`.
  - `period` and `high_time` keep their last values.
- **Arithmetic**
  - Counters never wrap, because `TIMEOUT<=2^WIDTH-1`.
  - `period+1` is computed at WIDTH bits.
- **Reset** (async, any time, including mid-measurement)
  - State goes to IDLE.
  - All synchronizer flops, `s_prev`, counters, `period`, `high_time`, `valid` and `timeout` go to 0.

## Timing
- Latency from a `sig_in` rising transition to the `valid` strobe is `SYNC_STAGES`+1 cycles, plus up to one cycle of synchronizer uncertainty.
- `valid` is high for exactly one cycle per measured period. The minimum spacing between strobes is 2 cycles.
- The minimum measurable period is 2 cycles (`sig_in` toggling every cycle). Inputs with high or low phases shorter than 1 cycle are unsupported.
- `timeout` rises 1 cycle after the cycle in which `cnt==TIMEOUT-1`.
- Results and flags are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `PERIOD_METER_HIGH_TIME_EN`.
- **Defined:** `hi_cnt` and the `high_time` register are implemented as described in Operation.
- **Undefined:**
  - `hi_cnt` is not built.
  - `high_time` is constant 0.
  - The port remains present so the interface is identical in both builds.
  - `period`, `valid` and `timeout` behave identically in both builds.

## Test plan
- **Divide-by-4, 50% duty:** `sig_in` synchronous to `in_clk`, high 2 cycles / low 2 cycles, `enable=1` → from the second rise onward, `valid` every 4 cycles with `period=4` and `high_time=2` (0 without the macro).
- **Minimum period:** `sig_in` toggles every cycle → `period=2`, `high_time=1`, `valid` every 2 cycles.
- **Timeout:** `TIMEOUT=16`, one rise then `sig_in` held low → no `valid`, `timeout=1` 16 cycles after the rise, FSM in IDLE. The next two rises spaced 5 cycles apart → `period=5`, `valid` pulses, `timeout=0`.
- **Enable drop:** after `period=4` is latched, drop `enable` for 10 cycles, then raise it → `valid` stays 0 while low and `period` holds 4. The first rise after re-enable produces no `valid`; the second gives `period=4`.
- **Async reset mid-measurement:** assert `reset` between `in_clk` edges partway through a period → all outputs are 0 immediately. After release, the first result appears only after two rises.
- **Duty sweep:** period 10 with high times 1, 5 and 9 → `high_time` = 1, 5, 9 and `period=10` throughout.

Source files
------------

// File: rtl/period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : period_meter                                               |
// | Description : Measures the period (and optionally the high time) of a    |
// |               slow, possibly asynchronous signal in in_clk cycles and    |
// |               publishes one result per input period with a valid strobe. |
// |               Optional feature macro: PERIOD_METER_HIGH_TIME_EN enables  |
// |               the high-time counter; otherwise high_time is constant 0.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  // Last count value before a measurement is abandoned.
  localparam logic [WIDTH-1:0] c_timeout_last = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] c_one          = WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_period;
  logic                   r_valid;
  logic                   r_timeout;

  logic w_s_sync;
  logic w_rise;
  logic w_start;
  logic w_done;
  logic w_expire;

  assign w_s_sync = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s_sync & ~r_s_prev;

  // Decoded events shared by the period path and the optional high-time path.
  assign w_start  = enable & (r_state == ST_IDLE) & w_rise;
  assign w_done   = enable & (r_state == ST_MEASURE) & w_rise;
  assign w_expire = enable & (r_state == ST_MEASURE) & ~w_rise & (r_cnt == c_timeout_last);

  // Synchronizer chain plus one edge-detect flop; free-running out of reset.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_prev <= w_s_sync;
    end
  end

  // Measurement FSM: period counter, result register, valid strobe, sticky timeout.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_rise) begin
              r_state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              // A coincident rise beats the timeout: the period is still valid.
              r_period  <= r_cnt + c_one;
              r_valid   <= 1'b1;
              r_timeout <= 1'b0;
              r_cnt     <= '0;
            end else if (r_cnt == c_timeout_last) begin
              r_timeout <= 1'b1;
              r_state   <= ST_IDLE;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] r_hi_cnt;
  logic [WIDTH-1:0] r_high_time;

  // High-cycle counter; starts at 1 because s_sync is high in the rise cycle.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_hi_cnt    <= '0;
      r_high_time <= '0;
    end else begin
      if (w_done) begin
        r_high_time <= r_hi_cnt;
      end
      if (w_start || w_done) begin
        r_hi_cnt <= c_one;
      end else if (!enable || w_expire || (r_state == ST_IDLE)) begin
        r_hi_cnt <= '0;
      end else if (w_s_sync) begin
        r_hi_cnt <= r_hi_cnt + c_one;
      end
    end
  end

  assign high_time = r_high_time;
`else
  assign high_time = '0;
`endif

  assign period  = r_period;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_period_meter                                            |
// | Description : Directed, table-driven self-checking bench for             |
// |               period_meter (TIMEOUT=16, SYNC_STAGES=2).                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_period_meter;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;

  logic             in_clk;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;

  period_meter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  // Strobe monitor: counts valid pulses, captures results, tracks spacing.
  int          cyc        = 0;
  int          n_valid    = 0;
  int          last_vcyc  = -1;
  int          min_space  = 1000;
  logic [31:0] cap_period = '0;
  logic [31:0] cap_high   = '0;

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (valid === 1'b1) begin
      n_valid    = n_valid + 1;
      cap_period = period;
      cap_high   = high_time;
      if (last_vcyc >= 0 && (cyc - last_vcyc) < min_space) min_space = cyc - last_vcyc;
      last_vcyc  = cyc;
    end
  end

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] exp_hi(input int h);
`ifdef PERIOD_METER_HIGH_TIME_EN
    return 32'(h);
`else
    return (h == -12345) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic clear_mon();
    n_valid   = 0;
    last_vcyc = -1;
    min_space = 1000;
  endtask

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      sig_in = 1'b1;
      repeat (hi) tick();
      sig_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{hi: 2, lo: 2, n: 4, exp_period: 4,  exp_high: 2};
    vecs[1] = '{hi: 1, lo: 1, n: 6, exp_period: 2,  exp_high: 1};
    vecs[2] = '{hi: 1, lo: 9, n: 3, exp_period: 10, exp_high: 1};
    vecs[3] = '{hi: 5, lo: 5, n: 3, exp_period: 10, exp_high: 5};
    vecs[4] = '{hi: 9, lo: 1, n: 3, exp_period: 10, exp_high: 9};
    vecs[5] = '{hi: 3, lo: 4, n: 3, exp_period: 7,  exp_high: 3};
    vecs[6] = '{hi: 8, lo: 8, n: 2, exp_period: 16, exp_high: 8};

    // Reset state
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick();
    chk("reset_period",  period,  32'd0);
    chk("reset_high",    high_time, 32'd0);
    chk("reset_valid",   32'(valid),   32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Table-driven periodic waveforms: n+1 rises give n results
    foreach (vecs[i]) begin
      enable = 1'b1;
      repeat (2) tick();
      clear_mon();
      drive_wave(vecs[i].hi, vecs[i].lo, vecs[i].n);
      sig_in = 1'b1;
      repeat (vecs[i].hi) tick();
      sig_in = 1'b0;
      repeat (6) tick();
      chk($sformatf("vec%0d_count", i),   32'(n_valid), 32'(vecs[i].n));
      chk($sformatf("vec%0d_period", i),  cap_period, 32'(vecs[i].exp_period));
      chk($sformatf("vec%0d_high", i),    cap_high, exp_hi(vecs[i].exp_high));
      chk($sformatf("vec%0d_spacing", i), 32'(min_space), 32'(vecs[i].exp_period));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
      enable = 1'b0;
      repeat (3) tick();
    end

    // Timeout: single rise then low; flag rises 16 cycles after the detected rise
    enable = 1'b1;
    sig_in = 1'b0;
    repeat (3) tick();
    clear_mon();
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    repeat (17) tick();
    chk("to_before", 32'(timeout), 32'd0);
    tick();
    chk("to_set",    32'(timeout), 32'd1);
    chk("to_novalid", 32'(n_valid), 32'd0);
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    repeat (4) tick();
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("to_first_rise_novalid", 32'(n_valid), 32'd0);
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    repeat (5) tick();
    chk("to_recover_count",  32'(n_valid), 32'd1);
    chk("to_recover_period", cap_period, 32'd5);
    chk("to_recover_high",   cap_high, exp_hi(1));
    chk("to_cleared",        32'(timeout), 32'd0);

    // Enable drop: period holds, no strobes while low, re-arm on first rise
    drive_wave(2, 2, 3);
    sig_in = 1'b1;
    repeat (2) tick();
    sig_in = 1'b0;
    repeat (2) tick();
    chk("en_period_latched", period, 32'd4);
    enable = 1'b0;
    clear_mon();
    drive_wave(2, 2, 2);
    repeat (2) tick();
    chk("en_low_novalid", 32'(n_valid), 32'd0);
    chk("en_low_hold",    period, 32'd4);
    enable = 1'b1;
    drive_wave(2, 2, 1);
    chk("en_first_rise_novalid", 32'(n_valid), 32'd0);
    sig_in = 1'b1;
    repeat (2) tick();
    sig_in = 1'b0;
    repeat (4) tick();
    chk("en_second_count",  32'(n_valid), 32'd1);
    chk("en_second_period", cap_period, 32'd4);

    // Async reset between clock edges, mid-measurement
    sig_in = 1'b1;
    repeat (2) tick();
    sig_in = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("areset_period",  period, 32'd0);
    chk("areset_high",    high_time, 32'd0);
    chk("areset_valid",   32'(valid), 32'd0);
    chk("areset_timeout", 32'(timeout), 32'd0);
    tick();
    reset = 1'b0;
    clear_mon();
    repeat (2) tick();
    drive_wave(3, 3, 1);
    chk("areset_first_rise_novalid", 32'(n_valid), 32'd0);
    drive_wave(3, 3, 1);
    chk("areset_second_count",  32'(n_valid), 32'd1);
    chk("areset_second_period", cap_period, 32'd6);
    chk("areset_second_high",   cap_high, exp_hi(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
